// File: rtl/wddl_adder_sequencer_pkg.sv
// Shared types and defaults for the WDDL adder sequencer.
package wddl_pkg;
  localparam int WDDL_WIDTH       = 13;
  localparam int WDDL_PRE_CYCLES  = 2;
  localparam int WDDL_EVAL_CYCLES = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    EVAL = 2'd2,
    RESP = 2'd3
  } wddl_state_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/wddl_adder_sequencer_if.sv
// Request/response handshake bundle between the clients and the sequencer.
interface wddl_adder_sequencer_if
  import wddl_pkg::*;
#(
  parameter int WIDTH = WDDL_WIDTH
);
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [WIDTH-1:0] req_a0;
  logic [WIDTH-1:0] req_b0;
  logic [WIDTH-1:0] req_a1;
  logic [WIDTH-1:0] req_b1;
  logic             resp_valid;
  logic             resp_ready;
  logic             resp_id;
  logic [WIDTH:0]   resp_sum;
  logic             resp_err;

  modport master (
    output req_valid, req_a0, req_b0, req_a1, req_b1, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_sum, resp_err
  );

  modport slave (
    input  req_valid, req_a0, req_b0, req_a1, req_b1, resp_ready,
    output req_ready, resp_valid, resp_id, resp_sum, resp_err
  );
endinterface

// File: rtl/wddl_adder_sequencer_rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant, remembers the last winner.
module wddl_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic [1:0] gnt_o,
  output logic       gnt_id_o
);
  logic rr_last_q;
  logic pri;

  // Requester that did not win last time has priority; the other is the fallback.
  always_comb begin
    pri      = ~rr_last_q;
    gnt_id_o = req_i[pri] ? pri : ~pri;
    gnt_o    = (en_i && (|req_i)) ? (2'b01 << gnt_id_o) : 2'b00;
  end

  // rr_last resets to 1 so requester 0 wins the first contested grant.
  always_ff @(posedge clk) begin
    if (rst)          rr_last_q <= 1'b1;
    else if (|gnt_o)  rr_last_q <= gnt_id_o;
  end
endmodule

// File: rtl/wddl_adder_sequencer.sv
// Shares one WDDL adder between two requesters, running precharge then
// evaluation for every operation and checking rail complementarity.
module wddl_adder_sequencer
  import wddl_pkg::*;
#(
  parameter int WIDTH       = WDDL_WIDTH,
  parameter int PRE_CYCLES  = WDDL_PRE_CYCLES,
  parameter int EVAL_CYCLES = WDDL_EVAL_CYCLES
)(
  input  logic                  clk,
  input  logic                  rst,
  wddl_adder_sequencer_if.slave bus,
  output logic [WIDTH-1:0]      add_a,
  output logic [WIDTH-1:0]      add_b,
  input  logic [WIDTH:0]        add_c,
  input  logic [WIDTH:0]        add_c_n,
  output logic                  busy
);
  localparam int CW = $clog2(max2(PRE_CYCLES, EVAL_CYCLES) + 1);
  localparam logic [CW-1:0] PRE_LAST  = CW'(PRE_CYCLES - 1);
  localparam logic [CW-1:0] EVAL_LAST = CW'(EVAL_CYCLES - 1);

  if (PRE_CYCLES < 1 || EVAL_CYCLES < 1) begin : g_bad_cfg
    $error("wddl_adder_sequencer: PRE_CYCLES and EVAL_CYCLES must be >= 1");
  end

  wddl_state_e      state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] op_a_q, op_b_q;
  logic             id_q;
  logic [WIDTH-1:0] add_a_q, add_b_q;
  logic             resp_valid_q, resp_id_q, resp_err_q;
  logic [WIDTH:0]   resp_sum_q;
  logic [1:0]       gnt;
  logic             gnt_id;

  wddl_rr_arb2 u_arb (
    .clk      (clk),
    .rst      (rst),
    .req_i    (bus.req_valid),
    .en_i     ((state_q == IDLE) && !rst),
    .gnt_o    (gnt),
    .gnt_id_o (gnt_id)
  );

  // Sequencer FSM: grant, precharge (operands 0), evaluate, hold response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      id_q         <= 1'b0;
      add_a_q      <= '0;
      add_b_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= 1'b0;
      resp_sum_q   <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (|gnt) begin
          op_a_q  <= gnt_id ? bus.req_a1 : bus.req_a0;
          op_b_q  <= gnt_id ? bus.req_b1 : bus.req_b0;
          id_q    <= gnt_id;
          cnt_q   <= '0;
          state_q <= PRE;
        end
        PRE: if (cnt_q == PRE_LAST) begin
          cnt_q   <= '0;
          add_a_q <= op_a_q;
          add_b_q <= op_b_q;
          state_q <= EVAL;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
        EVAL: if (cnt_q == EVAL_LAST) begin
          // Sample the rails while operands are still applied, then precharge.
          cnt_q        <= '0;
          add_a_q      <= '0;
          add_b_q      <= '0;
          resp_sum_q   <= add_c;
          resp_err_q   <= (add_c != ~add_c_n);
          resp_id_q    <= id_q;
          resp_valid_q <= 1'b1;
          state_q      <= RESP;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
        RESP: if (bus.resp_ready) begin
          resp_valid_q <= 1'b0;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = gnt;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_id    = resp_id_q;
  assign bus.resp_sum   = resp_sum_q;
  assign bus.resp_err   = resp_err_q;
  assign add_a          = add_a_q;
  assign add_b          = add_b_q;
  assign busy           = (state_q != IDLE);
endmodule
